// File: rtl/gnr_ctrl_pkg.sv
// Shared definitions for the gene-regulatory-network sequencing controller.
//   state_t        : controller phases (IDLE, LOAD, RUN, DONE)
//   NUM_NODES_DEF  : default number of node cells
//   STEP_W_DEF     : default width of the step counter / step limit
package gnr_ctrl_pkg;

  localparam int unsigned NUM_NODES_DEF = 8;
  localparam int unsigned STEP_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/gnr_sync_ctrl.sv
// Sequencing controller for one Boolean GRN instance. Loads an initial state
// into all nodes, then issues lock-step pulses (s1 every step, s0 every other
// step inside the node) until the slow and fast trajectories meet.
// Optional feature macro: GNR_SYNC_CTRL_TIMEOUT_EN (honor max_steps).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             run request, accepted in IDLE or DONE
//   init_vec          initial network state, captured on accepted start
//   max_steps         step limit (timeout build only)
//   s0_vec, s1_vec    slow / fast node states observed from the array
//   reset_nos         one-cycle load pulse to all nodes
//   init_state        captured initial state driven to the nodes
//   start_s0/start_s1 step pulses (combinational, same-cycle compare gated)
//   busy, done        LOAD/RUN indicator, DONE level
//   timeout, steps    run ended by limit/saturation, pulses issued
module gnr_sync_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int unsigned NUM_NODES = NUM_NODES_DEF,
  parameter int unsigned STEP_W    = STEP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] init_vec,
  input  logic [STEP_W-1:0]    max_steps,
  input  logic [NUM_NODES-1:0] s0_vec,
  input  logic [NUM_NODES-1:0] s1_vec,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [STEP_W-1:0]    steps
);

  state_t                 state, state_d;
  logic [STEP_W-1:0]      steps_d;
  logic                   timeout_d;
  logic [NUM_NODES-1:0]   init_d;
  logic                   pulse;
  logic                   match;
  logic                   limit_hit;

  // Odd step counts are skipped: after one pulse both trajectories are equal.
  assign match = ~steps[0] && (steps != '0) && (s0_vec == s1_vec);

`ifdef GNR_SYNC_CTRL_TIMEOUT_EN
  assign limit_hit = (steps == max_steps);
`else
  logic unused_max_steps;
  assign unused_max_steps = ^max_steps;
  assign limit_hit        = 1'b0;
`endif

  // The pulse depends on this cycle's compare, so it cannot be a registered output.
  assign start_s0 = pulse;
  assign start_s1 = pulse;

  // Next-state, counter and pulse decision.
  always_comb begin
    state_d   = state;
    steps_d   = steps;
    timeout_d = timeout;
    init_d    = init_state;
    pulse     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          init_d    = init_vec;
          steps_d   = '0;
          timeout_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (match) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (limit_hit || (steps == {STEP_W{1'b1}})) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          pulse   = 1'b1;
          steps_d = steps + STEP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      steps      <= '0;
      timeout    <= 1'b0;
      init_state <= '0;
      reset_nos  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      steps      <= steps_d;
      timeout    <= timeout_d;
      init_state <= init_d;
      reset_nos  <= (state_d == LOAD);
      busy       <= (state_d == LOAD) || (state_d == RUN);
      done       <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_gnr_sync_ctrl.sv
// Self-checking bench for gnr_sync_ctrl: a behavioural node array closes the
// loop, and a trajectory-meeting reference model predicts steps/timeout.
module tb_gnr_sync_ctrl;

  localparam int unsigned NN = 8;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NN-1:0] init_vec = '0;
  logic [SW-1:0] max_steps = '0;
  logic [NN-1:0] s0_vec = '0;
  logic [NN-1:0] s1_vec = '0;
  logic          reset_nos, start_s0, start_s1, busy, done, timeout;
  logic [NN-1:0] init_state;
  logic [SW-1:0] steps;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] tbl [256];
  int         mode = 0;
  logic       tog = 1'b0;

  always #5 clk = ~clk;

  gnr_sync_ctrl #(.NUM_NODES(NN), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .init_vec(init_vec),
    .max_steps(max_steps), .s0_vec(s0_vec), .s1_vec(s1_vec),
    .reset_nos(reset_nos), .init_state(init_state), .start_s0(start_s0),
    .start_s1(start_s1), .busy(busy), .done(done), .timeout(timeout),
    .steps(steps)
  );

  // Network update rule: 0 hold, 1 three-node ring, 2 random table, 3 counter.
  function automatic logic [7:0] net_f(input logic [7:0] x);
    case (mode)
      0:       return x;
      1:       return {x[7:3], x[1:0], x[2]};
      2:       return tbl[x];
      default: return x + 8'd1;
    endcase
  endfunction

  // Node array: s1 steps every pulse, s0 steps on every other pulse.
  always @(posedge clk) begin
    if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      tog    <= 1'b0;
    end else begin
      if (start_s1) s1_vec <= net_f(s1_vec);
      if (start_s0) begin
        if (!tog) s0_vec <= net_f(s0_vec);
        tog <= ~tog;
      end
    end
  end

  // Reference: after k steps slow = f^ceil(k/2)(x), fast = f^k(x).
  function automatic void ref_run(input logic [7:0] x, input logic [15:0] ms,
                                  output int n, output bit to);
    logic [7:0] a, b;
    a = x;
    b = x;
    for (int k = 0; k <= 65535; k++) begin
      if ((k % 2 == 0) && (k != 0) && (a == b)) begin
        n = k; to = 1'b0; return;
      end
`ifdef GNR_SYNC_CTRL_TIMEOUT_EN
      if (k == int'(ms)) begin
        n = k; to = 1'b1; return;
      end
`endif
      if (k == 65535) begin
        n = k; to = 1'b1; return;
      end
      b = net_f(b);
      if (k % 2 == 0) a = net_f(a);
    end
    n = 65535;
    to = 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full run: start, LOAD checks, per-cycle pulse checks, result checks.
  task automatic run(input logic [7:0] iv, input int m, input logic [15:0] ms,
                     input int exp_n, input bit exp_to, input bit mid_start);
    int nb, np;
    bit first;
    mode = m;
    max_steps = ms;
    init_vec = iv;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_pulse", 32'(reset_nos), 32'd1);
    check("load_init", 32'(init_state), 32'(iv));
    check("load_busy", 32'(busy), 32'd1);
    check("load_done", 32'(done), 32'd0);
    check("load_steps", 32'(steps), 32'd0);
    check("load_nopulse", 32'(start_s0), 32'd0);
    nb = 1;
    np = 0;
    first = 1'b1;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      start = mid_start && (c == 2);
      if (first) check("first_pulse", 32'(start_s0), 32'(exp_n != 0));
      first = 1'b0;
      if (start_s0 !== start_s1) check("pulse_pair", 32'(start_s1), 32'(start_s0));
      if (start_s0 && reset_nos) check("pulse_vs_load", 32'(reset_nos), 32'd0);
      if (busy) nb++;
      if (start_s0) np++;
    end
    start = 1'b0;
    check("done", 32'(done), 32'd1);
    check("steps", 32'(steps), 32'(exp_n));
    check("timeout", 32'(timeout), 32'(exp_to));
    check("pulse_count", 32'(np), 32'(exp_n));
    check("busy_cycles", 32'(nb), 32'(exp_n + 2));
    check("init_held", 32'(init_state), 32'(iv));
    if (!exp_to) check("met", 32'(s0_vec), 32'(s1_vec));
  endtask

  initial begin
    int  rn;
    bit  rto;
    logic [7:0]  iv;
    logic [15:0] ms;

    for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_reset_nos", 32'(reset_nos), 32'd0);
    check("rst_init", 32'(init_state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_steps", 32'(steps), 32'd0);
    check("rst_pulse", 32'(start_s0 | start_s1), 32'd0);

    // Hold network, ring oscillator (with an ignored start mid-run).
    run(8'hA5, 0, 16'd100, 2, 1'b0, 1'b0);
    run(8'h01, 1, 16'd100, 6, 1'b0, 1'b1);

`ifdef GNR_SYNC_CTRL_TIMEOUT_EN
    run(8'h00, 3, 16'd4, 4, 1'b1, 1'b0);
    run(8'h3C, 3, 16'd0, 0, 1'b1, 1'b0);
`else
    run(8'h00, 3, 16'd4, 512, 1'b0, 1'b0);
`endif

    // Reset in the middle of a run.
    mode = 3;
    max_steps = 16'd1000;
    init_vec = 8'h10;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && steps != 16'd3; c++) @(negedge clk);
    check("pre_rst_steps", 32'(steps), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_outputs",
          32'({reset_nos, start_s0, start_s1, busy, done, timeout}), 32'd0);
    check("mid_rst_steps", 32'(steps), 32'd0);
    check("mid_rst_init", 32'(init_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(8'h5A, 0, 16'd100, 2, 1'b0, 1'b0);

    // Randomized networks against the reference model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
      iv = 8'($urandom);
`ifdef GNR_SYNC_CTRL_TIMEOUT_EN
      ms = 16'($urandom_range(0, 40));
`else
      ms = 16'($urandom);
`endif
      mode = 2;
      ref_run(iv, ms, rn, rto);
      run(iv, 2, ms, rn, rto, r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
